// File: rtl/sound_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sound_scheduler
// Purpose  : Arbitrates four sound sources (free game, brick, paddle, side
//            wall) onto a single set of tone-generator gates.  Each source
//            plays for a fixed number of milliseconds.  A higher-priority
//            source pre-empts, a same-source hit retriggers, and lower-priority
//            hits are remembered and played afterwards.
//            Priority: FREE > BRICK > PADDLE > WALL.
// Ports    : CLK_DRV      in   clock, rising edge
//            RESET        in   asynchronous active-high reset
//            BRICK_HIT_N  in   brick hit strobe, falling edge = event
//            VB_HIT_N     in   side-wall hit strobe, falling edge = event
//            BP_HIT_N     in   paddle hit strobe, falling edge = event
//            FREE_GAME    in   free-game award, rising edge = event
//            ATTRACT_N    in   low = attract mode (only FREE may sound)
//            BRICK_EN     out  brick tone gate
//            VB_EN        out  wall tone gate
//            P_EN         out  paddle tone gate
//            FREE_EN      out  free-game tone gate
//            BUSY         out  any gate high
//            BRICK_PEND   out  brick hits waiting to be played
//            DROP         out  one-cycle pulse when a brick hit is discarded
// Revision : 1.0 - initial release
// ============================================================================
module sound_scheduler #(
    parameter int CLK_PER_MS = 57273,
    parameter int BRICK_MS   = 23,
    parameter int WALL_MS    = 23,
    parameter int PADDLE_MS  = 10,
    parameter int FREE_MS    = 250,
    parameter int QDEPTH_W   = 4
) (
    input  logic                CLK_DRV,
    input  logic                RESET,
    input  logic                BRICK_HIT_N,
    input  logic                VB_HIT_N,
    input  logic                BP_HIT_N,
    input  logic                FREE_GAME,
    input  logic                ATTRACT_N,
    output logic                BRICK_EN,
    output logic                VB_EN,
    output logic                P_EN,
    output logic                FREE_EN,
    output logic                BUSY,
    output logic [QDEPTH_W-1:0] BRICK_PEND,
    output logic                DROP
);

    // Source codes double as priority: a smaller code is a higher priority.
    localparam logic [1:0] C_SRC_FREE   = 2'd0;
    localparam logic [1:0] C_SRC_BRICK  = 2'd1;
    localparam logic [1:0] C_SRC_PADDLE = 2'd2;
    localparam logic [1:0] C_SRC_WALL   = 2'd3;

    // Counter is sized for the longest play of any source.
    localparam int C_MAX_BW  = (BRICK_MS > WALL_MS) ? BRICK_MS : WALL_MS;
    localparam int C_MAX_PF  = (PADDLE_MS > FREE_MS) ? PADDLE_MS : FREE_MS;
    localparam int C_MAX_MS  = (C_MAX_BW > C_MAX_PF) ? C_MAX_BW : C_MAX_PF;
    localparam int C_MAX_CYC = C_MAX_MS * CLK_PER_MS;
    localparam int C_CNT_W   = $clog2(C_MAX_CYC + 1);

    localparam logic [C_CNT_W-1:0] C_LOAD_FREE   = C_CNT_W'(FREE_MS   * CLK_PER_MS - 1);
    localparam logic [C_CNT_W-1:0] C_LOAD_BRICK  = C_CNT_W'(BRICK_MS  * CLK_PER_MS - 1);
    localparam logic [C_CNT_W-1:0] C_LOAD_PADDLE = C_CNT_W'(PADDLE_MS * CLK_PER_MS - 1);
    localparam logic [C_CNT_W-1:0] C_LOAD_WALL   = C_CNT_W'(WALL_MS   * CLK_PER_MS - 1);
    localparam logic [QDEPTH_W-1:0] C_PEND_MAX   = '1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_cur;
    logic [1:0]           w_cur_nxt;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [C_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_pend_p;
    logic                 w_pend_p_nxt;
    logic                 r_pend_w;
    logic                 w_pend_w_nxt;
    logic [QDEPTH_W-1:0]  r_brick_pend;
    logic [QDEPTH_W-1:0]  w_brick_pend_nxt;
    logic                 r_drop;
    logic                 w_drop_nxt;

    // Input history: *_q is the latest registered sample, *_p the one before.
    logic r_brick_q, r_brick_p, r_vb_q, r_vb_p, r_bp_q, r_bp_p;
    logic r_free_q, r_free_p, r_attract_n_q;

    logic [3:0] w_ev;        // events indexed by source code
    logic [3:0] w_req;       // events plus remembered requests
    logic [3:0] w_taken;     // source started/retriggered this edge
    logic [3:0] w_left;      // events that must be remembered
    logic [1:0] w_sel;
    logic [1:0] w_hi;
    logic       w_inc;
    logic       w_dec;

    function automatic logic [1:0] f_first(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [C_CNT_W-1:0] f_load(input logic [1:0] src);
        logic [C_CNT_W-1:0] v;
        case (src)
            C_SRC_FREE:   v = C_LOAD_FREE;
            C_SRC_BRICK:  v = C_LOAD_BRICK;
            C_SRC_PADDLE: v = C_LOAD_PADDLE;
            default:      v = C_LOAD_WALL;
        endcase
        return v;
    endfunction

    // In attract mode only the free-game source may raise an event, and
    // remembered requests are invisible until the queues have been flushed.
    assign w_ev[C_SRC_FREE]   = r_free_q & ~r_free_p;
    assign w_ev[C_SRC_BRICK]  = r_attract_n_q & r_brick_p & ~r_brick_q;
    assign w_ev[C_SRC_PADDLE] = r_attract_n_q & r_bp_p & ~r_bp_q;
    assign w_ev[C_SRC_WALL]   = r_attract_n_q & r_vb_p & ~r_vb_q;

    assign w_req = w_ev | (r_attract_n_q ? {r_pend_w, r_pend_p, |r_brick_pend, 1'b0} : 4'b0);

    always_comb begin
        w_state_nxt      = r_state;
        w_cur_nxt        = r_cur;
        w_cnt_nxt        = r_cnt;
        w_pend_p_nxt     = r_pend_p;
        w_pend_w_nxt     = r_pend_w;
        w_brick_pend_nxt = r_brick_pend;
        w_drop_nxt       = 1'b0;
        w_taken          = 4'b0;
        w_dec            = 1'b0;
        w_sel            = f_first(w_req);
        w_hi             = f_first(w_ev);

        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_state_nxt    = ST_PLAY;
                    w_cur_nxt      = w_sel;
                    w_cnt_nxt      = f_load(w_sel);
                    w_taken[w_sel] = 1'b1;
                    // A fresh brick hit starts directly; only a queued one is consumed.
                    w_dec = (w_sel == C_SRC_BRICK) && !w_ev[C_SRC_BRICK];
                    if (w_sel == C_SRC_PADDLE) w_pend_p_nxt = 1'b0;
                    if (w_sel == C_SRC_WALL)   w_pend_w_nxt = 1'b0;
                end
            end
            ST_PLAY: begin
                if (!r_attract_n_q && (r_cur != C_SRC_FREE) && !w_ev[C_SRC_FREE]) begin
                    w_state_nxt = ST_IDLE;
                end else if (|w_ev && (w_hi < r_cur)) begin
                    // Pre-emption: the old source is simply abandoned.
                    w_cur_nxt     = w_hi;
                    w_cnt_nxt     = f_load(w_hi);
                    w_taken[w_hi] = 1'b1;
                end else if (|w_ev && (w_hi == r_cur) && (w_hi != C_SRC_BRICK)) begin
                    // Retrigger; brick hits queue instead so each one is heard.
                    w_cnt_nxt     = f_load(w_hi);
                    w_taken[w_hi] = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - C_CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_left = w_ev & ~w_taken;
        w_inc  = w_left[C_SRC_BRICK];
        if (w_left[C_SRC_PADDLE]) w_pend_p_nxt = 1'b1;
        if (w_left[C_SRC_WALL])   w_pend_w_nxt = 1'b1;

        if (!r_attract_n_q) begin
            w_pend_p_nxt     = 1'b0;
            w_pend_w_nxt     = 1'b0;
            w_brick_pend_nxt = '0;
        end else if (w_inc && !w_dec) begin
            if (r_brick_pend == C_PEND_MAX) w_drop_nxt = 1'b1;
            else                            w_brick_pend_nxt = r_brick_pend + QDEPTH_W'(1);
        end else if (w_dec && !w_inc) begin
            w_brick_pend_nxt = r_brick_pend - QDEPTH_W'(1);
        end
    end

    always_ff @(posedge CLK_DRV or posedge RESET) begin
        if (RESET) begin
            // History preset to idle levels so release never looks like an edge.
            r_brick_q     <= 1'b1;
            r_brick_p     <= 1'b1;
            r_vb_q        <= 1'b1;
            r_vb_p        <= 1'b1;
            r_bp_q        <= 1'b1;
            r_bp_p        <= 1'b1;
            r_free_q      <= 1'b0;
            r_free_p      <= 1'b0;
            r_attract_n_q <= 1'b1;
            r_state       <= ST_IDLE;
            r_cur         <= C_SRC_FREE;
            r_cnt         <= '0;
            r_pend_p      <= 1'b0;
            r_pend_w      <= 1'b0;
            r_brick_pend  <= '0;
            r_drop        <= 1'b0;
        end else begin
            r_brick_q     <= BRICK_HIT_N;
            r_brick_p     <= r_brick_q;
            r_vb_q        <= VB_HIT_N;
            r_vb_p        <= r_vb_q;
            r_bp_q        <= BP_HIT_N;
            r_bp_p        <= r_bp_q;
            r_free_q      <= FREE_GAME;
            r_free_p      <= r_free_q;
            r_attract_n_q <= ATTRACT_N;
            r_state       <= w_state_nxt;
            r_cur         <= w_cur_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pend_p      <= w_pend_p_nxt;
            r_pend_w      <= w_pend_w_nxt;
            r_brick_pend  <= w_brick_pend_nxt;
            r_drop        <= w_drop_nxt;
        end
    end

    assign BUSY       = (r_state == ST_PLAY);
    assign FREE_EN    = BUSY && (r_cur == C_SRC_FREE);
    assign BRICK_EN   = BUSY && (r_cur == C_SRC_BRICK);
    assign P_EN       = BUSY && (r_cur == C_SRC_PADDLE);
    assign VB_EN      = BUSY && (r_cur == C_SRC_WALL);
    assign BRICK_PEND = r_brick_pend;
    assign DROP       = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_sound_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_scheduler
// Purpose  : Self-checking bench for sound_scheduler: directed scenarios with
//            hand-computed expectations, then randomized traffic, all checked
//            every cycle against a behavioural model of the scheduling rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sound_scheduler;

    localparam int P_CLK_PER_MS = 10;
    localparam int P_BRICK_MS   = 3;
    localparam int P_WALL_MS    = 3;
    localparam int P_PADDLE_MS  = 2;
    localparam int P_FREE_MS    = 5;
    localparam int P_QDEPTH_W   = 2;
    localparam int C_PEND_CAP   = (1 << P_QDEPTH_W) - 1;

    logic CLK_DRV     = 1'b0;
    logic RESET       = 1'b1;
    logic BRICK_HIT_N = 1'b1;
    logic VB_HIT_N    = 1'b1;
    logic BP_HIT_N    = 1'b1;
    logic FREE_GAME   = 1'b0;
    logic ATTRACT_N   = 1'b1;
    logic BRICK_EN, VB_EN, P_EN, FREE_EN, BUSY, DROP;
    logic [P_QDEPTH_W-1:0] BRICK_PEND;

    sound_scheduler #(
        .CLK_PER_MS (P_CLK_PER_MS),
        .BRICK_MS   (P_BRICK_MS),
        .WALL_MS    (P_WALL_MS),
        .PADDLE_MS  (P_PADDLE_MS),
        .FREE_MS    (P_FREE_MS),
        .QDEPTH_W   (P_QDEPTH_W)
    ) u_dut (
        .CLK_DRV     (CLK_DRV),
        .RESET       (RESET),
        .BRICK_HIT_N (BRICK_HIT_N),
        .VB_HIT_N    (VB_HIT_N),
        .BP_HIT_N    (BP_HIT_N),
        .FREE_GAME   (FREE_GAME),
        .ATTRACT_N   (ATTRACT_N),
        .BRICK_EN    (BRICK_EN),
        .VB_EN       (VB_EN),
        .P_EN        (P_EN),
        .FREE_EN     (FREE_EN),
        .BUSY        (BUSY),
        .BRICK_PEND  (BRICK_PEND),
        .DROP        (DROP)
    );

    always #5 CLK_DRV = ~CLK_DRV;

    // ------------------------------------------------------------------
    // Behavioural model.  Sources: 0 free, 1 brick, 2 paddle, 3 wall;
    // a lower number wins.  m_play = -1 means silent.
    // ------------------------------------------------------------------
    int       m_play    = -1;
    int       m_left    = 0;      // gate cycles still to be heard
    int       m_pend    = 0;
    bit       m_fp      = 1'b0;
    bit       m_fw      = 1'b0;
    bit       m_drop    = 1'b0;
    bit       m_att     = 1'b1;
    bit [3:0] m_now_lv  = 4'b0;   // asserted levels as last sampled
    bit [3:0] m_old_lv  = 4'b0;   // asserted levels sampled one edge earlier

    function automatic int dur(input int s);
        case (s)
            0:       return P_FREE_MS * P_CLK_PER_MS;
            1:       return P_BRICK_MS * P_CLK_PER_MS;
            2:       return P_PADDLE_MS * P_CLK_PER_MS;
            default: return P_WALL_MS * P_CLK_PER_MS;
        endcase
    endfunction

    function automatic int lowest(input bit [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_play = -1; m_left = 0; m_pend = 0;
        m_fp = 1'b0; m_fw = 1'b0; m_drop = 1'b0; m_att = 1'b1;
        m_now_lv = 4'b0; m_old_lv = 4'b0;
    endtask

    task automatic model_edge();
        bit [3:0] ev;
        bit [3:0] want;
        int taken;
        int pick;
        ev = m_now_lv & ~m_old_lv;
        if (!m_att) ev[3:1] = 3'b0;
        taken  = -1;
        m_drop = 1'b0;
        if (!m_att && m_play > 0 && !ev[0]) begin
            m_play = -1;
        end else if (m_play < 0) begin
            want = ev;
            if (m_att) begin
                want[1] |= (m_pend > 0);
                want[2] |= m_fp;
                want[3] |= m_fw;
            end
            pick = lowest(want);
            if (pick >= 0) begin
                m_play = pick; m_left = dur(pick); taken = pick;
                if (pick == 1 && !ev[1]) m_pend--;
                if (pick == 2) m_fp = 1'b0;
                if (pick == 3) m_fw = 1'b0;
            end
        end else begin
            pick = lowest(ev);
            if (pick >= 0 && pick < m_play) begin
                m_play = pick; m_left = dur(pick); taken = pick;
            end else if (pick >= 0 && pick == m_play && pick != 1) begin
                m_left = dur(pick); taken = pick;
            end else begin
                m_left--;
                if (m_left == 0) m_play = -1;
            end
        end
        for (int i = 1; i < 4; i++) begin
            if (ev[i] && i != taken) begin
                if (i == 1) begin
                    if (m_pend == C_PEND_CAP) m_drop = 1'b1;
                    else m_pend++;
                end else if (i == 2) m_fp = 1'b1;
                else m_fw = 1'b1;
            end
        end
        if (!m_att) begin
            m_pend = 0; m_fp = 1'b0; m_fw = 1'b0;
        end
        m_old_lv = m_now_lv;
        m_now_lv = {~VB_HIT_N, ~BP_HIT_N, ~BRICK_HIT_N, FREE_GAME};
        m_att    = ATTRACT_N;
    endtask

    always @(posedge CLK_DRV or posedge RESET) begin
        if (RESET) model_reset();
        else       model_edge();
    end

    // ------------------------------------------------------------------
    // Checking and observation (all in the stimulus process).
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    int act_prev = -1;
    int idle_cnt = 0;
    int cur_len  = 0;
    int open_gap = 0;
    int win_src[$];
    int win_len[$];
    int win_gap[$];
    int peak_pend = 0;
    int n_drop    = 0;

    function automatic logic gate(input int g);
        logic [3:0] v;
        v = {VB_EN, P_EN, BRICK_EN, FREE_EN};
        return v[g];
    endfunction

    function automatic int active();
        if (FREE_EN)  return 0;
        if (BRICK_EN) return 1;
        if (P_EN)     return 2;
        if (VB_EN)    return 3;
        return -1;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic compare_cycle();
        logic [7:0] got;
        logic [7:0] exp_v;
        got   = {FREE_EN, BRICK_EN, P_EN, VB_EN, BUSY, DROP, BRICK_PEND};
        exp_v = {m_play == 0, m_play == 1, m_play == 2, m_play == 3, m_play >= 0,
                 m_drop, 2'(m_pend)};
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t FREE/BRICK/P/VB/BUSY/DROP/PEND got %b required %b",
                     $time, got, exp_v);
        end
    endtask

    task automatic track();
        int a;
        a = active();
        if (int'(BRICK_PEND) > peak_pend) peak_pend = int'(BRICK_PEND);
        if (DROP) n_drop++;
        if (a == act_prev) begin
            if (a >= 0) cur_len++;
            else idle_cnt++;
        end else begin
            if (act_prev >= 0) begin
                win_src.push_back(act_prev);
                win_len.push_back(cur_len);
                win_gap.push_back(open_gap);
                idle_cnt = 0;
            end
            if (a >= 0) begin
                open_gap = (act_prev >= 0) ? 0 : idle_cnt;
                cur_len  = 1;
            end else begin
                idle_cnt = 1;
            end
        end
        act_prev = a;
    endtask

    task automatic clear_track();
        win_src.delete(); win_len.delete(); win_gap.delete();
        act_prev = active(); idle_cnt = 0; cur_len = 0; open_gap = 0;
        peak_pend = 0; n_drop = 0;
    endtask

    // Inputs change 3 time units after each rising edge; outputs are sampled there too.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK_DRV);
            #3;
            compare_cycle();
            track();
        end
    endtask

    task automatic wait_gate(input string name, input int g, input int bound);
        int n;
        n = 0;
        while (gate(g) !== 1'b1 && n < bound) begin
            step(1);
            n++;
        end
        check(name, int'(gate(g)), 1);
    endtask

    task automatic check_window(input string name, input int idx, input int src,
                                input int len, input int gap);
        if (idx < win_len.size()) begin
            check({name, "_src"}, win_src[idx], src);
            check({name, "_len"}, win_len[idx], len);
            if (gap >= 0) check({name, "_gap"}, win_gap[idx], gap);
        end else begin
            check({name, "_present"}, win_len.size(), idx + 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(3);
        check("reset_busy", int'(BUSY), 0);
        check("reset_pend", int'(BRICK_PEND), 0);
        RESET = 1'b0;
        step(3);

        // Single paddle hit: gate one cycle after the registered edge, 20 cycles long.
        clear_track();
        BP_HIT_N = 1'b0;
        step(1);
        check("p_not_early", int'(P_EN), 0);
        BP_HIT_N = 1'b1;
        step(1);
        check("p_rise_k1", int'(P_EN), 1);
        check("p_busy", int'(BUSY), 1);
        step(25);
        check("p_windows", win_len.size(), 1);
        check_window("p_win", 0, 2, 20, -1);

        // Four brick hits two cycles apart: four 30-cycle plays, one idle cycle between.
        clear_track();
        for (int i = 0; i < 4; i++) begin
            BRICK_HIT_N = 1'b0; step(1);
            BRICK_HIT_N = 1'b1; step(1);
        end
        step(140);
        check("b4_windows", win_len.size(), 4);
        check_window("b4_w0", 0, 1, 30, -1);
        for (int i = 1; i < 4; i++) check_window("b4_wn", i, 1, 30, 1);
        check("b4_peak", peak_pend, 3);
        check("b4_drops", n_drop, 0);

        // Five brick hits during a free-game play: queue caps at 3, the two
        // hits beyond the cap are discarded, then three brick plays follow.
        clear_track();
        FREE_GAME = 1'b1; step(2);
        check("f_up", int'(FREE_EN), 1);
        for (int i = 0; i < 5; i++) begin
            BRICK_HIT_N = 1'b0; step(1);
            BRICK_HIT_N = 1'b1; step(1);
        end
        FREE_GAME = 1'b0;
        check("f5_pend", int'(BRICK_PEND), 3);
        check("f5_drops", n_drop, 2);
        step(150);
        check("f5_windows", win_len.size(), 4);
        check_window("f5_free", 0, 0, 50, -1);
        for (int i = 1; i < 4; i++) check_window("f5_brick", i, 1, 30, 1);

        // Wall hit during paddle play, then free game on the 5th paddle cycle.
        clear_track();
        BP_HIT_N = 1'b0; step(1);
        BP_HIT_N = 1'b1;
        wait_gate("pw_p_up", 2, 10);
        VB_HIT_N = 1'b0; step(1);
        VB_HIT_N = 1'b1; step(2);
        FREE_GAME = 1'b1; step(1);
        check("pw_p_still", int'(P_EN), 1);
        step(1);
        check("pw_p_down", int'(P_EN), 0);
        check("pw_f_up", int'(FREE_EN), 1);
        FREE_GAME = 1'b0;
        step(100);
        check("pw_windows", win_len.size(), 3);
        check_window("pw_paddle", 0, 2, 5, -1);
        check_window("pw_free", 1, 0, 50, 0);
        check_window("pw_wall", 2, 3, 30, 1);

        // Attract mode during a brick play with two queued.
        clear_track();
        for (int i = 0; i < 3; i++) begin
            BRICK_HIT_N = 1'b0; step(1);
            BRICK_HIT_N = 1'b1; step(1);
        end
        check("at_pend2", int'(BRICK_PEND), 2);
        check("at_brick_on", int'(BRICK_EN), 1);
        ATTRACT_N = 1'b0;
        step(2);
        check("at_brick_off", int'(BRICK_EN), 0);
        check("at_pend0", int'(BRICK_PEND), 0);
        BRICK_HIT_N = 1'b0; step(1);
        BRICK_HIT_N = 1'b1; step(3);
        check("at_brick_ignored", int'(BUSY), 0);
        FREE_GAME = 1'b1; step(2);
        FREE_GAME = 1'b0;
        step(60);
        check("at_windows", win_len.size(), 2);
        check_window("at_free", 1, 0, 50, -1);
        ATTRACT_N = 1'b1;
        step(3);

        // Reset in the middle of a wall play drops the gate without a clock edge.
        VB_HIT_N = 1'b0; step(1);
        VB_HIT_N = 1'b1;
        wait_gate("rs_wall_up", 3, 10);
        step(5);
        RESET = 1'b1;
        #1;
        check("rs_vb_async", int'(VB_EN), 0);
        check("rs_busy_async", int'(BUSY), 0);
        step(2);
        RESET = 1'b0;
        clear_track();
        step(60);
        check("rs_no_gate", win_len.size() + ((act_prev >= 0) ? 1 : 0), 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            BRICK_HIT_N = ($urandom_range(0, 11) != 0);
            BP_HIT_N    = ($urandom_range(0, 24) != 0);
            VB_HIT_N    = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 59) == 0) FREE_GAME = ~FREE_GAME;
            if (ATTRACT_N) begin
                if ($urandom_range(0, 299) == 0) ATTRACT_N = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                ATTRACT_N = 1'b1;
            end
            if (RESET) RESET = 1'b0;
            else if ($urandom_range(0, 999) == 0) RESET = 1'b1;
            step(1);
        end
        BRICK_HIT_N = 1'b1; BP_HIT_N = 1'b1; VB_HIT_N = 1'b1;
        FREE_GAME = 1'b0; ATTRACT_N = 1'b1; RESET = 1'b0;
        step(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
